// File: rtl/counter_mon_pkg.sv
// Shared constants for the counter event monitor.
// Register map, CTRL bit positions and default counter width.
package counter_mon_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CTRL_EDGE_BOTH = 0;
  localparam int CTRL_EN        = 1;

  localparam int CNT_W_DEF = 8;
  localparam int N_CH      = 3;

endpackage

// File: rtl/mon_sync_edge.sv
// Two-flop synchronizer, history flop and edge select.
// Emits one registered pulse per detected edge.
module mon_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  input  logic edge_both,
  input  logic det_en,
  output logic pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic h_q, h_d;
  logic pulse_q, pulse_d;
  logic edge_hit;

  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    h_d  = s2_q;
    edge_hit = edge_both ? (s2_q ^ h_q)
                         : (s2_q & ~h_q);
    pulse_d = edge_hit & det_en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      h_q     <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      h_q     <= h_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/counter_event_monitor.sv
// Event monitor for the three outputs of a 3-channel counter.
// Sticky status, saturating counts, mask and level interrupt.
module counter_event_monitor
  import counter_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        counter0_OUT,
  input  logic        counter1_OUT,
  input  logic        counter2_OUT,
  input  logic        mon_we,
  input  logic        mon_rd,
  input  logic [1:0]  mon_addr,
  input  logic [31:0] mon_wdata,
  output logic [31:0] mon_rdata,
  output logic        irq
);

  logic [N_CH-1:0]  ch_in;
  logic [N_CH-1:0]  pulse;
  logic [N_CH-1:0]  evt;
  logic [N_CH-1:0]  status_q, status_d;
  logic [N_CH-1:0]  status_clr;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [1:0]       arm_q, arm_d;
  logic             armed;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [31:0]      cnt_rd;
  logic [31:0]      rd_val;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             unused_wdata;

  assign ch_in = {counter2_OUT, counter1_OUT, counter0_OUT};
  assign unused_wdata = ^mon_wdata[31:3];

  // Armed only once the arm counter has saturated, so a
  // level already present at reset release is not an edge.
  assign armed = (arm_q == 2'd3);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mon_sync_edge u_sync (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (ch_in[i]),
      .edge_both (ctrl_q[CTRL_EDGE_BOTH]),
      .det_en    (armed),
      .pulse     (pulse[i])
    );
  end

  always_comb begin
    status_clr = '0;
    mask_d     = mask_q;
    ctrl_d     = ctrl_q;
    cnt_clr    = 1'b0;
    if (mon_we) begin
      unique case (mon_addr)
        ADDR_STATUS: status_clr = mon_wdata[2:0];
        ADDR_MASK:   mask_d     = mon_wdata[2:0];
        ADDR_COUNT:  cnt_clr    = 1'b1;
        ADDR_CTRL:   ctrl_d     = mon_wdata[1:0];
      endcase
    end

    evt = pulse & {N_CH{ctrl_q[CTRL_EN]}};
    status_d = (status_q & ~status_clr) | evt;

    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (evt[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    arm_d = armed ? arm_q : arm_q + 2'd1;

    cnt_rd = '0;
    cnt_rd[CNT_W-1:0]         = cnt_q[0];
    cnt_rd[2*CNT_W-1:CNT_W]   = cnt_q[1];
    cnt_rd[3*CNT_W-1:2*CNT_W] = cnt_q[2];

    rd_val = '0;
    unique case (mon_addr)
      ADDR_STATUS: rd_val[2:0] = status_q;
      ADDR_MASK:   rd_val[2:0] = mask_q;
      ADDR_COUNT:  rd_val      = cnt_rd;
      ADDR_CTRL:   rd_val[1:0] = ctrl_q;
    endcase

    rdata_d = mon_rd ? rd_val : rdata_q;
    irq_d   = |(status_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q <= '0;
      mask_q   <= '0;
      ctrl_q   <= '0;
      arm_q    <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      ctrl_q   <= ctrl_d;
      arm_q    <= arm_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign mon_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_counter_event_monitor.sv
// Directed bench for counter_event_monitor.
// Expected values are hand-derived from the register map.
module tb_counter_event_monitor;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_MASK   = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  logic        clk;
  logic        rst;
  logic        c0, c1, c2;
  logic        mon_we;
  logic        mon_rd;
  logic [1:0]  mon_addr;
  logic [31:0] mon_wdata;
  logic [31:0] mon_rdata;
  logic        irq;

  int n_tests;
  int n_fail;
  logic [31:0] rv;

  counter_event_monitor #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .counter0_OUT (c0),
    .counter1_OUT (c1),
    .counter2_OUT (c2),
    .mon_we       (mon_we),
    .mon_rd       (mon_rd),
    .mon_addr     (mon_addr),
    .mon_wdata    (mon_wdata),
    .mon_rdata    (mon_rdata),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    mon_we    = 1'b1;
    mon_addr  = a;
    mon_wdata = d;
    tick();
    mon_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [31:0] d);
    mon_rd   = 1'b1;
    mon_addr = a;
    tick();
    mon_rd   = 1'b0;
    d        = mon_rdata;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    c0        = 1'b0;
    c1        = 1'b0;
    c2        = 1'b0;
    mon_we    = 1'b0;
    mon_rd    = 1'b0;
    mon_addr  = 2'd0;
    mon_wdata = '0;
    #2;
    tick(3);
    check("rst_rdata", mon_rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b1;

    rd(A_STATUS, rv); check("rst_status", rv, 32'h0);
    rd(A_MASK, rv);   check("rst_mask", rv, 32'h0);
    rd(A_COUNT, rv);  check("rst_count", rv, 32'h0);
    rd(A_CTRL, rv);   check("rst_ctrl", rv, 32'h0);

    // Single rising event on channel 1
    wr(A_CTRL, 32'h2);
    wr(A_MASK, 32'h7);
    tick(2);
    c1 = 1'b1;
    tick(4);
    check("ev1_irq_pre", {31'b0, irq}, 32'h0);
    rd(A_STATUS, rv);
    check("ev1_status", rv, 32'h2);
    check("ev1_irq", {31'b0, irq}, 32'h1);
    c1 = 1'b0;
    rd(A_COUNT, rv);
    check("ev1_count", rv, 32'h100);
    tick(4);
    wr(A_STATUS, 32'h2);
    check("w1c_irq_hold", {31'b0, irq}, 32'h1);
    tick();
    check("w1c_irq_clr", {31'b0, irq}, 32'h0);
    rd(A_STATUS, rv);
    check("w1c_status", rv, 32'h0);
    rd(A_COUNT, rv);
    check("fall_no_evt", rv, 32'h100);

    // Both-edge counting and saturation
    wr(A_CTRL, 32'h3);
    wr(A_COUNT, 32'h0);
    rd(A_COUNT, rv);
    check("cnt_clear", rv, 32'h0);
    for (int i = 0; i < 10; i++) begin
      c0 = ~c0;
      tick(4);
    end
    tick();
    rd(A_COUNT, rv);
    check("both_cnt10", rv, 32'h0A);
    for (int i = 0; i < 290; i++) begin
      c0 = ~c0;
      tick(4);
    end
    tick();
    rd(A_COUNT, rv);
    check("sat_cnt", rv, 32'hFF);
    rd(A_STATUS, rv);
    check("sat_status", rv, 32'h1);

    // Input high across reset release, enable at once
    c2  = 1'b1;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    wr(A_CTRL, 32'h2);
    tick(10);
    rd(A_STATUS, rv);
    check("arm_status", rv, 32'h0);
    rd(A_COUNT, rv);
    check("arm_count", rv, 32'h0);
    check("arm_irq", {31'b0, irq}, 32'h0);

    // Event coincident with W1C: set wins
    c0 = 1'b1;
    tick(3);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, rv);
    check("set_wins", rv, 32'h1);
    rd(A_COUNT, rv);
    check("cnt_one", rv, 32'h1);

    // Event coincident with COUNT write: clear wins
    c0 = 1'b0;
    tick(5);
    c0 = 1'b1;
    tick(3);
    wr(A_COUNT, 32'h0);
    rd(A_COUNT, rv);
    check("clr_wins", rv, 32'h0);

    // Mask gating and read-during-W1C
    c0 = 1'b0;
    c2 = 1'b0;
    tick(5);
    c0 = 1'b1;
    c1 = 1'b1;
    c2 = 1'b1;
    tick(6);
    rd(A_STATUS, rv);
    check("all_status", rv, 32'h7);
    check("mask0_irq", {31'b0, irq}, 32'h0);
    wr(A_MASK, 32'h4);
    check("mask_irq_lag", {31'b0, irq}, 32'h0);
    tick();
    check("mask_irq", {31'b0, irq}, 32'h1);
    mon_rd    = 1'b1;
    mon_we    = 1'b1;
    mon_addr  = A_STATUS;
    mon_wdata = 32'h7;
    tick();
    mon_rd = 1'b0;
    mon_we = 1'b0;
    check("rd_prewrite", mon_rdata, 32'h7);
    tick();
    check("irq_drop", {31'b0, irq}, 32'h0);
    rd(A_STATUS, rv);
    check("rd_postwrite", rv, 32'h0);

    wr(A_MASK, 32'hFFFF_FFF9);
    rd(A_MASK, rv);
    check("mask_bits", rv, 32'h1);
    tick(3);
    check("rdata_hold", mon_rdata, 32'h1);
    rd(A_CTRL, rv);
    check("ctrl_rd", rv, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
